// File: rtl/disp_share_ctrl.sv
// disp_share_ctrl: shares one 4-digit display driver among three requesters.
// Round-robin ownership with a minimum hold time; the owner's digits, decimal
// points and blank mask are registered onto the driver outputs.
// Optional blink support is compiled in only when DISP_SHARE_BLINK_EN is defined.
// busy mirrors the FSM state (0 = IDLE, 1 = OWN) and serves as its debug view.
module disp_share_ctrl #(
   parameter int HOLD_CYCLES  = 50_000_000,
   parameter int BLINK_CYCLES = 25_000_000
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [2:0]  req,
   input  logic [47:0] hexs_in,
   input  logic [11:0] points_in,
   input  logic [2:0]  blink_in,
   output logic [15:0] Hexs,
   output logic [3:0]  Points,
   output logic [3:0]  LES,
   output logic [2:0]  grant,
   output logic        busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

   // Round-robin search: first set bit of r at or above start, wrapping at 2.
   function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] start);
      logic [1:0] idx;
      logic [1:0] pick;
      logic       found;
      idx   = start;
      pick  = start;
      found = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
      return pick;
   endfunction

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   state_t        state_q, state_d;
   logic [1:0]    owner_q, owner_d;
   logic [1:0]    ptr_q, ptr_d;      // search start for the next IDLE->OWN grant
   logic [HW-1:0] cnt_q, cnt_d;
   logic [2:0]    grant_q, grant_d;
   logic          busy_q, busy_d;
   logic [15:0]   hexs_q, hexs_d;
   logic [3:0]    points_q, points_d;
   logic [3:0]    les_q, les_d;
   logic [2:0]    others;
   logic          blank_blink;

`ifdef DISP_SHARE_BLINK_EN
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;

   // Free-running blink timer: phase flips once every BLINK_CYCLES cycles.
   always_comb begin
      bcnt_d  = bcnt_q + BW'(1);
      phase_d = phase_q;
      if (bcnt_q == BLINK_MAX) begin
         bcnt_d  = '0;
         phase_d = ~phase_q;
      end
   end

   // Blank the digits during the "off" half of the owner's blink period.
   always_comb begin
      case (owner_d)
         2'd0:    blank_blink = blink_in[0] & phase_d;
         2'd1:    blank_blink = blink_in[1] & phase_d;
         default: blank_blink = blink_in[2] & phase_d;
      endcase
   end
`else
   logic unused_blink;
   assign unused_blink = ^blink_in;
   assign blank_blink  = 1'b0;
`endif

   // Next-state arbitration: grant from IDLE, hand over on release or hold expiry.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      others  = req & ~grant_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (|req) begin
               state_d = ST_OWN;
               owner_d = rr_pick(req, ptr_q);
            end
         end
         default: begin
            if (!req[owner_q]) begin
               cnt_d = '0;
               if (|others) begin
                  owner_d = rr_pick(others, next_idx(owner_q));
               end else begin
                  state_d = ST_IDLE;
               end
            end else if ((cnt_q == HOLD_MAX) && (|others)) begin
               cnt_d   = '0;
               owner_d = rr_pick(others, next_idx(owner_q));
            end else if (cnt_q != HOLD_MAX) begin
               cnt_d = cnt_q + HW'(1);
            end
         end
      endcase
      ptr_d = (state_d == ST_OWN) ? next_idx(owner_d) : ptr_q;
   end

   // Output data for the next cycle, taken from the incoming owner's slice.
   always_comb begin
      grant_d  = 3'b000;
      busy_d   = 1'b0;
      hexs_d   = 16'h0000;
      points_d = 4'h0;
      les_d    = 4'b1111;
      if (state_d == ST_OWN) begin
         grant_d = 3'b001 << owner_d;
         busy_d  = 1'b1;
         les_d   = blank_blink ? 4'b1111 : 4'b0000;
         case (owner_d)
            2'd0: begin
               hexs_d   = hexs_in[15:0];
               points_d = points_in[3:0];
            end
            2'd1: begin
               hexs_d   = hexs_in[31:16];
               points_d = points_in[7:4];
            end
            default: begin
               hexs_d   = hexs_in[47:32];
               points_d = points_in[11:8];
            end
         endcase
      end
   end

   // State and registered outputs; RST overrides everything.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         owner_q  <= 2'd0;
         ptr_q    <= 2'd0;
         cnt_q    <= '0;
         grant_q  <= 3'b000;
         busy_q   <= 1'b0;
         hexs_q   <= 16'h0000;
         points_q <= 4'h0;
         les_q    <= 4'b1111;
`ifdef DISP_SHARE_BLINK_EN
         bcnt_q   <= '0;
         phase_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
         hexs_q   <= hexs_d;
         points_q <= points_d;
         les_q    <= les_d;
`ifdef DISP_SHARE_BLINK_EN
         bcnt_q   <= bcnt_d;
         phase_q  <= phase_d;
`endif
      end
   end

   assign Hexs   = hexs_q;
   assign Points = points_q;
   assign LES    = les_q;
   assign grant  = grant_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Bench for disp_share_ctrl with HOLD_CYCLES=8, BLINK_CYCLES=4.
// A reference model predicts each cycle's outputs into exp_q; after every
// clock edge the DUT outputs are popped and compared, plus directed checks.
module tb_disp_share_ctrl;

   localparam int HOLD  = 8;
   localparam int BLINK = 4;

   logic        clk;
   logic        RST;
   logic [2:0]  req;
   logic [47:0] hexs_in;
   logic [11:0] points_in;
   logic [2:0]  blink_in;
   logic [15:0] Hexs;
   logic [3:0]  Points;
   logic [3:0]  LES;
   logic [2:0]  grant;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   // expected word: {grant[2:0], busy, Hexs[15:0], Points[3:0], LES[3:0]}
   logic [27:0] exp_q[$];

   // reference model state
   int m_own;     // -1 = idle
   int m_start;
   int m_cnt;
   int m_bcnt;
   bit m_phase;

   disp_share_ctrl #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
      .clk(clk), .RST(RST), .req(req), .hexs_in(hexs_in), .points_in(points_in),
      .blink_in(blink_in), .Hexs(Hexs), .Points(Points), .LES(LES),
      .grant(grant), .busy(busy)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_search(input logic [2:0] r, input int from);
      for (int k = 0; k < 3; k++) begin
         if (r[(from + k) % 3]) return (from + k) % 3;
      end
      return -1;
   endfunction

   // Advance the model by one edge and push its predicted outputs.
   task automatic m_step();
      logic [2:0]  mine;
      logic [2:0]  oth;
      logic [2:0]  g;
      logic [15:0] h;
      logic [3:0]  p;
      logic [3:0]  l;
      if (RST) begin
         m_own = -1; m_start = 0; m_cnt = 0; m_bcnt = 0; m_phase = 1'b0;
      end else begin
`ifdef DISP_SHARE_BLINK_EN
         if (m_bcnt == BLINK - 1) begin
            m_bcnt  = 0;
            m_phase = ~m_phase;
         end else begin
            m_bcnt++;
         end
`endif
         if (m_own < 0) begin
            if (req != 3'b000) begin
               m_own = m_search(req, m_start);
               m_cnt = 0;
            end
         end else begin
            mine = 3'b001 << m_own;
            oth  = req & ~mine;
            if ((req & mine) == 3'b000) begin
               m_cnt = 0;
               m_own = (oth != 3'b000) ? m_search(oth, (m_own + 1) % 3) : -1;
            end else if (m_cnt == HOLD - 1) begin
               if (oth != 3'b000) begin
                  m_own = m_search(oth, (m_own + 1) % 3);
                  m_cnt = 0;
               end
            end else begin
               m_cnt++;
            end
         end
         if (m_own >= 0) m_start = (m_own + 1) % 3;
      end
      if (m_own < 0) begin
         g = 3'b000; h = 16'h0; p = 4'h0; l = 4'b1111;
      end else begin
         g = 3'b001 << m_own;
         h = hexs_in[16*m_own +: 16];
         p = points_in[4*m_own +: 4];
         l = 4'b0000;
`ifdef DISP_SHARE_BLINK_EN
         if (blink_in[m_own] && m_phase) l = 4'b1111;
`endif
      end
      exp_q.push_back({g, (m_own >= 0), h, p, l});
   endtask

   // One clock: predict, clock, then compare away from the edge.
   task automatic do_cycle();
      logic [27:0] e;
      m_step();
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("sb_grant", {29'd0, grant}, {29'd0, e[27:25]});
         check("sb_busy", {31'd0, busy}, {31'd0, e[24]});
         check("sb_hexs", {16'd0, Hexs}, {16'd0, e[23:8]});
         check("sb_points", {28'd0, Points}, {28'd0, e[7:4]});
         check("sb_les", {28'd0, LES}, {28'd0, e[3:0]});
      end
   endtask

   logic [2:0] g_hist[0:40];

   initial begin
      RST = 1'b1; req = 3'b000; hexs_in = '0; points_in = '0; blink_in = 3'b000;
      m_own = -1; m_start = 0; m_cnt = 0; m_bcnt = 0; m_phase = 1'b0;
      #2;

      // reset state
      do_cycle();
      do_cycle();
      check("rst_grant", {29'd0, grant}, 32'd0);
      check("rst_les", {28'd0, LES}, 32'hF);

      // release with requester 1 holding 16'h1234
      RST = 1'b0;
      req = 3'b010;
      hexs_in = {16'h0000, 16'h1234, 16'h0000};
      points_in = 12'h0A0;
      do_cycle();
      check("r029_grant", {29'd0, grant}, 32'h2);
      check("r029_busy", {31'd0, busy}, 32'h1);
      check("r029_hexs", {16'd0, Hexs}, 32'h1234);
      check("r029_les", {28'd0, LES}, 32'h0);
      req = 3'b000;
      do_cycle();
      check("idle_grant", {29'd0, grant}, 32'd0);

      // two requesters alternating every HOLD cycles, live data changing
      req = 3'b011;
      for (int k = 1; k <= 25; k++) begin
         hexs_in = {$urandom(), $urandom()};
         points_in = 12'($urandom());
         do_cycle();
         g_hist[k] = grant;
      end
      check("r030_g1", {29'd0, g_hist[1]}, 32'h1);
      check("r030_g8", {29'd0, g_hist[8]}, 32'h1);
      check("r030_g9", {29'd0, g_hist[9]}, 32'h2);
      check("r030_g16", {29'd0, g_hist[16]}, 32'h2);
      check("r030_g17", {29'd0, g_hist[17]}, 32'h1);

      // owner 2 drops while requester 0 waits: direct handover, then idle
      req = 3'b000;
      do_cycle();
      req = 3'b100;
      do_cycle();
      do_cycle();
      check("r031_own2", {29'd0, grant}, 32'h4);
      req = 3'b001;
      do_cycle();
      check("r031_handover", {29'd0, grant}, 32'h1);
      req = 3'b000;
      do_cycle();
      check("r031_idle_grant", {29'd0, grant}, 32'h0);
      check("r031_idle_les", {28'd0, LES}, 32'hF);

      // reset in the middle of a hold with owner 1
      req = 3'b010;
      hexs_in = {16'h1111, 16'h2222, 16'h3333};
      do_cycle();
      do_cycle();
      do_cycle();
      check("r032_own1", {29'd0, grant}, 32'h2);
      RST = 1'b1;
      do_cycle();
      check("r032_rst_grant", {29'd0, grant}, 32'h0);
      check("r032_rst_busy", {31'd0, busy}, 32'h0);
      check("r032_rst_hexs", {16'd0, Hexs}, 32'h0);
      check("r032_rst_points", {28'd0, Points}, 32'h0);
      check("r032_rst_les", {28'd0, LES}, 32'hF);
      RST = 1'b0;
      req = 3'b110;
      do_cycle();
      check("r032_regrant", {29'd0, grant}, 32'h2);

      // single requester held for 20 cycles: no change, no glitch
      req = 3'b100;
      hexs_in = {16'hCAFE, 16'h2222, 16'h3333};
      do_cycle();
      for (int k = 0; k < 20; k++) begin
         do_cycle();
         check("r034_grant", {29'd0, grant}, 32'h4);
         check("r034_hexs", {16'd0, Hexs}, 32'hCAFE);
      end

      // owner with blink enabled
      blink_in = 3'b100;
      for (int k = 0; k < 16; k++) begin
         do_cycle();
`ifndef DISP_SHARE_BLINK_EN
         check("r033_les_steady", {28'd0, LES}, 32'h0);
`endif
      end

      // random traffic with occasional resets
      for (int k = 0; k < 400; k++) begin
         RST = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
         hexs_in = {$urandom(), $urandom()};
         points_in = 12'($urandom());
         blink_in = 3'($urandom_range(0, 7));
         do_cycle();
         check("onehot", {31'd0, $onehot0(grant)}, 32'h1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
